// File: rtl/switch_mcu_ahb_pkg.sv
// Shared AHB-Lite definitions for the MCU core bus.
// Holds the HTRANS/HSIZE/HRESP codes, the SRAM slave FSM state encoding and
// a helper that turns an access size and low address bits into byte lanes.
// The core-side master imports the same package so both ends agree on the codes.
package switch_mcu_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [3:0] HSIZE_BYTE = 4'd0;
  localparam logic [3:0] HSIZE_HALF = 4'd1;
  localparam logic [3:0] HSIZE_WORD = 4'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } sram_state_t;

  // Little-endian lane select: byte -> lane lo, half -> lanes {lo[1],0..1}, word -> all.
  function automatic logic [3:0] lane_mask(input logic [3:0] size, input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << lo;
      HSIZE_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/switch_mcu_sram_array.sv
// Word-organised storage array with per-byte write enables and asynchronous read.
// Kept in its own module so it can be replaced by a vendor memory macro.
// Ports:
//   clk    in  clock, write on rising edge
//   we     in  write enable
//   be     in  byte enables (DATA_W/8)
//   addr   in  word index, shared by read and write
//   wdata  in  write data
//   rdata  out combinational read of the addressed word
// Contents are deliberately not reset.
module switch_mcu_sram_array #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_W/8-1:0]     be,
  input  logic [DEPTH_LOG2-1:0]   addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/switch_mcu_ahb_sram.sv
// AHB-Lite SRAM slave for the MCU core bus.
// Accepts byte/half/word reads and writes inside a window starting at BASE_ADDR,
// inserts WAIT_STATES data-phase wait cycles, and answers out-of-window,
// misaligned or oversize accesses with a two-cycle ERROR response.
// Ports:
//   in_clk, in_rst           clock, asynchronous active-low reset
//   in_hsel .. in_hwdata     AHB-Lite slave inputs (hburst/hport/hmastlock ignored)
//   out_hready, out_hresp    transfer done / response
//   out_hrdata               read data; holds the last read word outside read data phases
module switch_mcu_ahb_sram
  import switch_mcu_ahb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_LOG2  = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 0
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_hsel,
  input  logic [ADDR_W-1:0] in_haddr,
  input  logic              in_hwrite,
  input  logic [3:0]        in_hsize,
  input  logic [2:0]        in_hburst,
  input  logic [3:0]        in_hport,
  input  logic [1:0]        in_htrans,
  input  logic              in_hmastlock,
  input  logic [DATA_W-1:0] in_hwdata,
  output logic              out_hready,
  output logic              out_hresp,
  output logic [DATA_W-1:0] out_hrdata
);

  sram_state_t             state, state_nxt;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    wr_q;
  logic [DATA_W/8-1:0]     be_q;
  logic [3:0]              cnt_q;
  logic [DATA_W-1:0]       hrdata_q;
  logic [DATA_W-1:0]       rd_data;

  // Bursts, protection and lock carry no meaning for a plain SRAM.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, in_hburst, in_hport, in_hmastlock};

  // Address-phase decode.
  logic [ADDR_W-1:0] offset;
  logic              in_window, misaligned, size_bad, illegal, accept;

  assign offset     = in_haddr - BASE_ADDR;
  // Upper offset bits must be zero: no wrap-around onto low words.
  assign in_window  = (in_haddr >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == '0);
  assign size_bad   = in_hsize > HSIZE_WORD;
  assign misaligned = ((in_hsize == HSIZE_HALF) && in_haddr[0]) ||
                      ((in_hsize == HSIZE_WORD) && (in_haddr[1:0] != 2'b00));
  assign illegal    = !in_window || size_bad || misaligned;
  assign accept     = out_hready && in_hsel && in_htrans[1];

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= ST_IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      cnt_q    <= '0;
      hrdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q <= offset[DEPTH_LOG2+1:2];
        wr_q  <= in_hwrite;
        be_q  <= lane_mask(in_hsize, in_haddr[1:0]);
        cnt_q <= 4'(WAIT_STATES);
      end else if (state == ST_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state == ST_DATA && !wr_q) hrdata_q <= rd_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (!accept)      state_nxt = ST_IDLE;
        else if (illegal) state_nxt = ST_ERR1;
        else              state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
      end
      ST_WAIT: if (cnt_q <= 4'd1) state_nxt = ST_DATA;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign out_hready = !((state == ST_WAIT) || (state == ST_ERR1));
  assign out_hresp  = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign out_hrdata = (state == ST_DATA && !wr_q) ? rd_data : hrdata_q;

  switch_mcu_sram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (in_clk),
    .we    (state == ST_DATA && wr_q),
    .be    (be_q),
    .addr  (idx_q),
    .wdata (in_hwdata),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_switch_mcu_ahb_sram.sv
// Directed bench for switch_mcu_ahb_sram: one instance with zero wait states and
// one with three, sharing the bus signals and selected by separate hsel lines.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_switch_mcu_ahb_sram;
  import switch_mcu_ahb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel0 = 1'b0, hsel3 = 1'b0;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [3:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [3:0]  hport = '0;
  logic [1:0]  htrans = HTRANS_IDLE;
  logic        hmastlock = 1'b0;
  logic [31:0] hwdata = '0;
  logic        hready0, hresp0, hready3, hresp3;
  logic [31:0] hrdata0, hrdata3;

  int tests = 0;
  int fails = 0;
  int lows;

  always #5 clk = ~clk;

  switch_mcu_ahb_sram #(.WAIT_STATES(0)) u_dut0 (
    .in_clk(clk), .in_rst(rst_n), .in_hsel(hsel0), .in_haddr(haddr),
    .in_hwrite(hwrite), .in_hsize(hsize), .in_hburst(hburst), .in_hport(hport),
    .in_htrans(htrans), .in_hmastlock(hmastlock), .in_hwdata(hwdata),
    .out_hready(hready0), .out_hresp(hresp0), .out_hrdata(hrdata0)
  );

  switch_mcu_ahb_sram #(.WAIT_STATES(3)) u_dut3 (
    .in_clk(clk), .in_rst(rst_n), .in_hsel(hsel3), .in_haddr(haddr),
    .in_hwrite(hwrite), .in_hsize(hsize), .in_hburst(hburst), .in_hport(hport),
    .in_htrans(htrans), .in_hmastlock(hmastlock), .in_hwdata(hwdata),
    .out_hready(hready3), .out_hresp(hresp3), .out_hrdata(hrdata3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                         input logic [3:0] sz);
    htrans = tr;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  task automatic idle();
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // Step through the wait-state instance's data phase; returns at the DATA
  // cycle's falling edge with the number of stalled cycles seen.
  task automatic wait_data3(input string tag, output int n);
    bit done;
    n = 0;
    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (hready3) done = 1;
      else n++;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    // Reset held for three cycles.
    repeat (3) @(negedge clk);
    chk("rst_hready0", {31'd0, hready0}, 32'd1);
    chk("rst_hresp0",  {31'd0, hresp0},  32'd0);
    chk("rst_hrdata0", hrdata0, 32'd0);
    chk("rst_hready3", {31'd0, hready3}, 32'd1);
    chk("rst_hrdata3", hrdata3, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_hready", {31'd0, hready0}, 32'd1);
    chk("post_rst_idle_hresp",  {31'd0, hresp0},  32'd0);

    // Zero wait states: write then immediate read of the same word.
    hsel0 = 1'b1;
    addr_ph(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD);
    @(negedge clk);
    chk("ws0_wr_hready", {31'd0, hready0}, 32'd1);
    hwdata = 32'hDEADBEEF;
    addr_ph(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("ws0_rd_hready", {31'd0, hready0}, 32'd1);
    chk("ws0_raw_data", hrdata0, 32'hDEADBEEF);
    idle();
    @(negedge clk);
    chk("ws0_hold_data", hrdata0, 32'hDEADBEEF);

    // Byte lanes, back-to-back pipeline on word 0.
    addr_ph(HTRANS_NONSEQ, 32'h0, 1'b1, HSIZE_WORD);
    @(negedge clk);
    hwdata = 32'h0000_0000;
    addr_ph(HTRANS_NONSEQ, 32'h3, 1'b1, HSIZE_BYTE);
    @(negedge clk);
    hwdata = 32'hAA55_6677;
    addr_ph(HTRANS_SEQ, 32'h0, 1'b1, HSIZE_HALF);
    @(negedge clk);
    hwdata = 32'h9999_1234;
    addr_ph(HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("lanes_read", hrdata0, 32'hAA00_1234);
    chk("lanes_hresp", {31'd0, hresp0}, 32'd0);

    // Error responses: out of window (would alias word 0), misaligned word, oversize.
    addr_ph(HTRANS_NONSEQ, 32'h1000, 1'b1, HSIZE_WORD);
    @(negedge clk);
    chk("err_oow_c1", {30'd0, hready0, hresp0}, 32'b01);
    idle();
    hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("err_oow_c2", {30'd0, hready0, hresp0}, 32'b11);
    addr_ph(HTRANS_NONSEQ, 32'h2, 1'b1, HSIZE_WORD);
    @(negedge clk);
    chk("err_misal_c1", {30'd0, hready0, hresp0}, 32'b01);
    idle();
    @(negedge clk);
    chk("err_misal_c2", {30'd0, hready0, hresp0}, 32'b11);
    addr_ph(HTRANS_NONSEQ, 32'h0, 1'b1, 4'd3);
    @(negedge clk);
    chk("err_size_c1", {30'd0, hready0, hresp0}, 32'b01);
    idle();
    @(negedge clk);
    chk("err_size_c2", {30'd0, hready0, hresp0}, 32'b11);
    addr_ph(HTRANS_NONSEQ, 32'h0, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("err_array_unchanged", hrdata0, 32'hAA00_1234);
    chk("err_then_okay", {30'd0, hready0, hresp0}, 32'b10);
    idle();
    hsel0 = 1'b0;
    @(negedge clk);

    // Three wait states: write, then read pipelined in the write's DATA cycle.
    hsel3 = 1'b1;
    addr_ph(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD);
    @(negedge clk);
    chk("ws3_wr_stall", {31'd0, hready3}, 32'd0);
    idle();
    hwdata = 32'hCAFE_F00D;
    wait_data3("ws3_wr", lows);
    chk("ws3_wr_lows", lows, 32'd2);  // first stalled cycle already consumed above
    addr_ph(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
    wait_data3("ws3_rd", lows);
    chk("ws3_rd_lows", lows, 32'd3);
    chk("ws3_rd_data", hrdata3, 32'hCAFE_F00D);

    // Burst with BUSY in the middle: exactly two beats of three stalls each.
    addr_ph(HTRANS_BUSY, 32'h14, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("busy_no_stall", {31'd0, hready3}, 32'd1);
    addr_ph(HTRANS_SEQ, 32'h14, 1'b0, HSIZE_WORD);
    wait_data3("seq_rd", lows);
    chk("seq_rd_lows", lows, 32'd3);
    idle();
    @(negedge clk);
    chk("burst_end_idle", {31'd0, hready3}, 32'd1);

    // Asynchronous reset during the WAIT of a write discards it.
    addr_ph(HTRANS_NONSEQ, 32'h10, 1'b1, HSIZE_WORD);
    @(negedge clk);
    idle();
    hwdata = 32'h1111_1111;
    chk("arst_pre_stall", {31'd0, hready3}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hready", {31'd0, hready3}, 32'd1);
    chk("arst_hrdata", hrdata3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    addr_ph(HTRANS_NONSEQ, 32'h10, 1'b0, HSIZE_WORD);
    wait_data3("arst_rd", lows);
    chk("arst_old_value", hrdata3, 32'hCAFE_F00D);
    idle();
    hsel3 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
